count_scheduler: RTL and testbench

COUNT_SCHEDULER -- requirements
Module: count_scheduler

---
 rtl/count_sched_pkg.sv | 14 +
 rtl/rr_pick.sv | 27 ++
 rtl/count_scheduler.sv | 108 ++++++++++
 tb/tb_count_scheduler.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_sched_pkg.sv
// Shared types and default sizing for the count scheduler and its round-robin picker.
package count_sched_pkg;

  localparam int DEF_NREQ  = 2;
  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin selector: one-hot of the first requesting index at or above ptr, wrapping.
module rr_pick
  import count_sched_pkg::*;
#(
  parameter int NREQ = DEF_NREQ
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         sel
);

  always_comb begin
    int  idx;
    logic found;
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        sel[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/count_scheduler.sv
// Time-shares one external counter between NREQ requesters: grant, clear, count to the
// requester's target, then pulse done and hand the counter to the next requester.
module count_scheduler
  import count_sched_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] target,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic                  cnt_clear,
  output logic                  cnt_enable,
  input  logic [WIDTH-1:0]      cnt_data,
  output state_e                state_dbg
);

  // Handshake: a requester raises req[i] and holds it; gnt[i] rises one cycle later and
  // stays high for the whole run; done[i] pulses once when the count reaches target[i].
  // Dropping req[i] while granted (before DONE) aborts the run with no done pulse.

  localparam int PW = $clog2(NREQ);

  state_e           state;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    gidx;
  logic [WIDTH-1:0] tgt_q;
  logic [NREQ-1:0]  pick;
  logic [PW-1:0]    pick_idx;
  logic [PW-1:0]    next_ptr;
  logic             gnt_req;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req (req),
    .ptr (ptr),
    .sel (pick)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick[i]) pick_idx = PW'(i);
    end
  end

  assign gnt_req    = |(req & gnt);
  assign next_ptr   = (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
  // Gated on the live req so an abort stops counting in the very cycle req drops.
  assign cnt_enable = (state == RUN) && gnt_req && (cnt_data != tgt_q);
  assign busy       = (state != IDLE);
  assign state_dbg  = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      gidx      <= '0;
      gnt       <= '0;
      done      <= '0;
      cnt_clear <= 1'b0;
      tgt_q     <= '0;
    end else begin
      done      <= '0;
      cnt_clear <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            gnt       <= pick;
            gidx      <= pick_idx;
            tgt_q     <= target[int'(pick_idx)*WIDTH +: WIDTH];
            cnt_clear <= 1'b1;
            state     <= CLEAR;
          end
        end
        CLEAR: begin
          if (!gnt_req) begin
            gnt   <= '0;
            ptr   <= next_ptr;
            state <= IDLE;
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
          if (!gnt_req) begin
            gnt   <= '0;
            ptr   <= next_ptr;
            state <= IDLE;
          end else if (cnt_data == tgt_q) begin
            done  <= gnt;
            state <= DONE;
          end
        end
        DONE: begin
          gnt   <= '0;
          ptr   <= next_ptr;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_count_scheduler.sv
// Bench for count_scheduler paired with a 4-bit clear/enable counter.
module tb_count_scheduler;
  import count_sched_pkg::*;

  localparam int NREQ  = 2;
  localparam int WIDTH = 4;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] target = '0;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic                  busy;
  logic                  cnt_clear;
  logic                  cnt_enable;
  logic [WIDTH-1:0]      cnt_data;
  state_e                state_dbg;

  int checks = 0;
  int errors = 0;
  int mptr   = 0;
  int tgt_model [NREQ];
  logic [NREQ-1:0] exp_q [$];

  // ---------------- clock / reset / counter ----------------
  always #5 clk = ~clk;

  logic [WIDTH-1:0] cnt_q = '0;
  always @(posedge clk) begin
    if (cnt_clear)       cnt_q <= '0;
    else if (cnt_enable) cnt_q <= cnt_q + 1'b1;
  end
  assign cnt_data = cnt_q;

  count_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .target     (target),
    .gnt        (gnt),
    .done       (done),
    .busy       (busy),
    .cnt_clear  (cnt_clear),
    .cnt_enable (cnt_enable),
    .cnt_data   (cnt_data),
    .state_dbg  (state_dbg)
  );

  // ---------------- helpers / reference model ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // First requester found walking the indices in rotation order from the pointer.
  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    int order [$];
    for (int k = 0; k < NREQ; k++) order.push_back((p + k) % NREQ);
    foreach (order[j]) if (r[order[j]]) return order[j];
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int idx);
    logic [NREQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  task automatic set_target(input int i, input int v);
    target[i*WIDTH +: WIDTH] = WIDTH'(v);
    tgt_model[i] = v;
  endtask

  task automatic push_expected();
    exp_q.push_back(onehot(pick(req, mptr)));
  endtask

  // Called with DUT idle and req already driven; expects a grant at the next edge.
  // new_tgt >= 0 rewrites the granted requester's target right after the grant.
  task automatic observe_run(input int new_tgt);
    logic [NREQ-1:0] exp_g;
    int idx, t, en_cnt, lat;
    bit seen;
    exp_g  = exp_q.pop_front();
    idx    = 0;
    for (int i = 0; i < NREQ; i++) if (exp_g[i]) idx = i;
    t      = tgt_model[idx];
    en_cnt = 0;
    lat    = 0;
    seen   = 1'b0;
    tick();
    chk("gnt", 32'(gnt), 32'(exp_g));
    chk("clear_pulse", 32'(cnt_clear), 1);
    chk("busy_run", 32'(busy), 1);
    chk("en_in_clear", 32'(cnt_enable), 0);
    if (new_tgt >= 0) set_target(idx, new_tgt);
    for (int c = 0; c < 40 && !seen; c++) begin
      tick();
      lat++;
      if (done !== '0) seen = 1'b1;
      else if (cnt_enable === 1'b1) en_cnt++;
      if (c == 0) chk("clear_once", 32'(cnt_clear), 0);
    end
    chk("done_seen", 32'(seen), 1);
    chk("done_vec", 32'(done), 32'(exp_g));
    chk("latency", 32'(lat), 32'(2 + t));
    chk("en_cycles", 32'(en_cnt), 32'(t));
    chk("cnt_at_done", 32'(cnt_data), 32'(t));
    tick();
    chk("gnt_cleared", 32'(gnt), 0);
    chk("done_one_cycle", 32'(done), 0);
    chk("cnt_no_wrap", 32'(cnt_data), 32'(t));
    chk("idle_after", 32'(busy), 0);
    mptr = (idx + 1) % NREQ;
  endtask

  // Abort the granted run after k cycles past the grant (k=0 drops req during CLEAR).
  task automatic observe_abort(input int k);
    int idx;
    idx = pick(req, mptr);
    tick();
    chk("abort_gnt", 32'(gnt), 32'(onehot(idx)));
    repeat (k) tick();
    if (k > 0) chk("abort_en_before", 32'(cnt_enable), 1);
    req = '0;
    #1;
    chk("abort_en_low", 32'(cnt_enable), 0);
    tick();
    chk("abort_gnt_clr", 32'(gnt), 0);
    chk("abort_no_done", 32'(done), 0);
    chk("abort_idle", 32'(busy), 0);
    if (k > 0) chk("abort_cnt", 32'(cnt_data), 32'(k - 1));
    mptr = (idx + 1) % NREQ;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int r, k, scr;
    tick();
    tick();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_clear", 32'(cnt_clear), 0);
    chk("rst_en", 32'(cnt_enable), 0);
    chk("rst_state", 32'(state_dbg), 32'(IDLE));
    rst_n = 1'b1;
    tick();

    // Both requesters held: strict alternation starting from index 0.
    set_target(0, 3);
    set_target(1, 2);
    req = 2'b11;
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b10);
    repeat (4) observe_run(-1);
    req = '0;
    tick();

    // Single requester, target 5.
    set_target(0, 5);
    req = 2'b01;
    push_expected();
    observe_run(-1);
    req = '0;

    // Target changed mid-run is ignored.
    set_target(0, 4);
    req = 2'b01;
    push_expected();
    observe_run(9);
    req = '0;

    // Boundary targets 0 and 15.
    set_target(0, 0);
    req = 2'b01;
    push_expected();
    observe_run(-1);
    req = '0;
    set_target(1, 15);
    req = 2'b10;
    push_expected();
    observe_run(-1);
    req = '0;

    // Abort at enable cycle 2 of 6; pointer must move on to index 1.
    set_target(0, 6);
    req = 2'b01;
    observe_abort(2);
    set_target(1, 1);
    req = 2'b11;
    push_expected();
    observe_run(-1);
    req = '0;

    // Reset mid-run, with the pointer sitting at 1 beforehand.
    set_target(0, 1);
    req = 2'b01;
    push_expected();
    observe_run(-1);
    req = '0;
    set_target(0, 8);
    req = 2'b01;
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_gnt", 32'(gnt), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_clear", 32'(cnt_clear), 0);
    chk("arst_en", 32'(cnt_enable), 0);
    req = '0;
    tick();
    rst_n = 1'b1;
    mptr = 0;
    tick();
    set_target(0, 2);
    set_target(1, 3);
    req = 2'b11;
    push_expected();
    observe_run(-1);
    req = 2'b10;
    push_expected();
    observe_run(-1);
    req = '0;

    // Randomized runs and aborts against the model.
    for (int n = 0; n < 30; n++) begin
      set_target(0, $urandom_range(0, 15));
      set_target(1, $urandom_range(0, 15));
      req = NREQ'($urandom_range(1, 3));
      r = $urandom_range(0, 3);
      if (r == 0) begin
        k = $urandom_range(0, tgt_model[pick(req, mptr)]);
        observe_abort(k);
      end else begin
        scr = (r == 1) ? $urandom_range(0, 15) : -1;
        push_expected();
        observe_run(scr);
        req = '0;
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
